// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end for the combinational 16-bit ALU.
// Registers one command onto the ALU ports and waits SETTLE_CYC cycles.
// It then captures the result words and flags, and holds them on a valid/ready
// response channel until the consumer takes them.
module alu_op_sequencer #(
  parameter int WIDTH      = 16,
  parameter int SEL_W      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out_1,
  input  logic [WIDTH-1:0] alu_out_0,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [2:0]       rsp_flags,
  output logic [SEL_W-1:0] rsp_sel,
  output logic [CNT_W-1:0] op_count
);

  // A settle time of 0 would capture on the accept edge; clamp it to 1.
  localparam int SC  = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int SCW = (SC > 1) ? $clog2(SC) : 1;
  localparam logic [SCW-1:0] SC_LOAD = SCW'(SC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_e;

  state_e           state_q;
  logic [SCW-1:0]   settle_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_hi_q, rsp_lo_q;
  logic [SEL_W-1:0] alu_sel_q, rsp_sel_q;
  logic [2:0]       rsp_flags_q;
  logic             rsp_valid_q;
  logic [CNT_W-1:0] op_count_q;

  // Ready is forced low while reset is held so nothing is handshaken then.
  assign cmd_ready = (state_q == IDLE) && !rst;

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_sel   = rsp_sel_q;
  assign op_count  = op_count_q;

  // Sequencer FSM: accept -> wait for ALU settle -> capture -> hand off response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_flags_q <= '0;
      rsp_sel_q   <= '0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_a_q   <= cmd_a;
            alu_b_q   <= cmd_b;
            alu_sel_q <= cmd_sel;
            settle_q  <= SC_LOAD;
            state_q   <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_q == '0) begin
            // ALU inputs have been stable for SC cycles; sample its outputs.
            rsp_hi_q    <= alu_out_1;
            rsp_lo_q    <= alu_out_0;
            rsp_flags_q <= {alu_v, alu_z, alu_c};
            rsp_sel_q   <= alu_sel_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        RESP: begin
          // Payload registers are left alone so they keep the last result.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
